// File: rtl/mips_trace_monitor_if.sv
// Retire-stream and trace-stream bundle for mips_trace_monitor.
// The master side is the CPU core plus the trace consumer; the slave side is the monitor.
interface mips_trace_monitor_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32
);
    localparam int REC_W = 4 + PC_W + DATA_W;

    // Retire stream: one instruction per cycle at most
    logic              ret_valid;
    logic [PC_W-1:0]   ret_pc;
    logic [5:0]        ret_opcode;
    logic [5:0]        ret_funct;
    logic [DATA_W-1:0] ret_wd;

    // Trace stream: valid/ready drain of {class, pc, wd} records
    logic              tr_ready;
    logic              tr_valid;
    logic [REC_W-1:0]  tr_data;

    modport master (
        output ret_valid, ret_pc, ret_opcode, ret_funct, ret_wd, tr_ready,
        input  tr_valid, tr_data
    );

    modport slave (
        input  ret_valid, ret_pc, ret_opcode, ret_funct, ret_wd, tr_ready,
        output tr_valid, tr_data
    );
endinterface

// File: rtl/mips_trace_monitor.sv
// Run monitor for the MIPS cores: classifies retiring instructions, keeps
// saturating per-class counters, bounds the run to CYCLE_LIMIT active cycles
// and buffers {class, pc, wd} trace records in a small FIFO.
module mips_trace_monitor #(
    parameter int CYCLE_LIMIT = 15,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mips_trace_monitor_if.slave  bus,
    input  logic                 clr,
    input  logic                 run_en,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [9*CNT_W-1:0]   cls_cnt,
    output logic                 overflow,
    output logic                 done
);
    localparam int N_CLS = 9;
    localparam int REC_W = 4 + PC_W + DATA_W;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(CYCLE_LIMIT);
    localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [3:0] {
        C_ADD   = 4'd0,
        C_SUB   = 4'd1,
        C_AND   = 4'd2,
        C_OR    = 4'd3,
        C_LW    = 4'd4,
        C_SW    = 4'd5,
        C_BEQ   = 4'd6,
        C_J     = 4'd7,
        C_OTHER = 4'd8
    } cls_t;

    state_t           state;
    cls_t             cls;
    logic             active;
    logic             rec_in;
    logic             push;
    logic             pop;
    logic [REC_W-1:0] rec;

    logic [CNT_W-1:0] cls_q [N_CLS];

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Decode the retiring instruction into its class code
    always_comb begin
        // NOTE: default assignment first so every path drives cls and no latch is inferred.
        cls = C_OTHER;
        if (bus.ret_opcode == 6'd0) begin
            case (bus.ret_funct)
                6'd32:   cls = C_ADD;
                6'd34:   cls = C_SUB;
                6'd36:   cls = C_AND;
                6'd37:   cls = C_OR;
                default: cls = C_OTHER;
            endcase
        end else begin
            case (bus.ret_opcode)
                6'd35:   cls = C_LW;
                6'd43:   cls = C_SW;
                6'd4:    cls = C_BEQ;
                6'd2:    cls = C_J;
                default: cls = C_OTHER;
            endcase
        end
    end

    // Active cycle = running and not paused; only then do retires count
    assign active = (state == S_RUN) && run_en;
    assign rec_in = active && bus.ret_valid && !clr;
    assign rec    = {cls, bus.ret_pc, bus.ret_wd};

    // FIFO handshake: a full FIFO still accepts a record when the head leaves the same cycle
    assign bus.tr_valid = (count != '0);
    assign bus.tr_data  = mem[rd_ptr];
    assign pop          = bus.tr_valid && bus.tr_ready && !clr;
    assign push         = rec_in && ((count != FULL) || pop);

    // Run FSM with cycle counter and registered done flag
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state     <= S_IDLE;
            cycle_cnt <= '0;
            done      <= 1'b0;
        end else if (clr) begin
            state     <= S_IDLE;
            cycle_cnt <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run_en) state <= S_RUN;
                end
                S_RUN: begin
                    if (run_en) begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                        if (cycle_cnt == LIMIT - 1'b1) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating per-class counters, bumped on each counted retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CLS; k++) cls_q[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < N_CLS; k++) cls_q[k] <= '0;
        end else if (active && bus.ret_valid && cls_q[cls] != CNT_MAX) begin
            cls_q[cls] <= cls_q[cls] + 1'b1;
        end
    end

    // Flatten the class counters onto the output bus, class k at [k*CNT_W +: CNT_W]
    always_comb begin
        cls_cnt = '0;
        for (int k = 0; k < N_CLS; k++) cls_cnt[k*CNT_W +: CNT_W] = cls_q[k];
    end

    // Trace storage write port
    always_ff @(posedge clk) begin
        // NOTE: the storage array is not reset; only pointers and count are, so stale words are never visible.
        if (push) mem[wr_ptr] <= rec;
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Sticky overflow: set when a counted record finds no room
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 overflow <= 1'b0;
        else if (clr)            overflow <= 1'b0;
        else if (rec_in && !push) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_mips_trace_monitor.sv
// Self-checking bench for mips_trace_monitor: randomized retire stream checked
// against a transaction-level reference model (counters + record queue).
module tb_mips_trace_monitor;
    localparam int CYCLE_LIMIT = 15;
    localparam int DEPTH       = 8;
    localparam int CNT_W       = 16;
    localparam int PC_W        = 32;
    localparam int DATA_W      = 32;
    localparam int N_CLS       = 9;
    localparam int REC_W       = 4 + PC_W + DATA_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clr;
    logic                 run_en;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [N_CLS*CNT_W-1:0] cls_cnt;
    logic                 overflow;
    logic                 done;

    mips_trace_monitor_if #(.PC_W(PC_W), .DATA_W(DATA_W)) bus ();

    mips_trace_monitor #(
        .CYCLE_LIMIT(CYCLE_LIMIT),
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W),
        .PC_W       (PC_W),
        .DATA_W     (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clr       (clr),
        .run_en    (run_en),
        .cycle_cnt (cycle_cnt),
        .cls_cnt   (cls_cnt),
        .overflow  (overflow),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: run started/finished flags, active-cycle count, class tallies, record queue
    bit               m_started;
    bit               m_finished;
    bit               m_ovf;
    int               m_cycles;
    int               m_cls [N_CLS];
    logic [REC_W-1:0] m_q [$];

    // Instruction table: the eight named classes, an op0 unknown funct, and an unknown opcode
    logic [5:0] op_tab [10] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd0, 6'd9};
    logic [5:0] fn_tab [10] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd0, 6'd0, 6'd0, 6'd0, 6'd42, 6'd0};

    function automatic int model_class(logic [5:0] op, logic [5:0] fn);
        if (op == 6'd0) begin
            if (fn == 6'd32) return 0;
            if (fn == 6'd34) return 1;
            if (fn == 6'd36) return 2;
            if (fn == 6'd37) return 3;
            return 8;
        end
        case (op)
            6'd35:   return 4;
            6'd43:   return 5;
            6'd4:    return 6;
            6'd2:    return 7;
            default: return 8;
        endcase
    endfunction

    function automatic logic [N_CLS*CNT_W-1:0] model_cls_vec();
        logic [N_CLS*CNT_W-1:0] v;
        v = '0;
        for (int k = 0; k < N_CLS; k++) v[k*CNT_W +: CNT_W] = CNT_W'(m_cls[k]);
        return v;
    endfunction

    task automatic model_reset();
        m_started  = 1'b0;
        m_finished = 1'b0;
        m_ovf      = 1'b0;
        m_cycles   = 0;
        for (int k = 0; k < N_CLS; k++) m_cls[k] = 0;
        m_q.delete();
    endtask

    // Apply one clock's worth of the rules to the model using the inputs held across the edge
    task automatic model_step();
        bit active;
        bit pop;
        int size_before;
        int c;
        if (clr) begin
            model_reset();
            return;
        end
        size_before = m_q.size();
        pop    = (size_before > 0) && bus.tr_ready;
        active = m_started && !m_finished && run_en;
        if (pop) void'(m_q.pop_front());
        if (active && bus.ret_valid) begin
            c = model_class(bus.ret_opcode, bus.ret_funct);
            if (size_before < DEPTH || pop) m_q.push_back({4'(c), bus.ret_pc, bus.ret_wd});
            else m_ovf = 1'b1;
            if (m_cls[c] < (1 << CNT_W) - 1) m_cls[c]++;
        end
        if (active) begin
            m_cycles++;
            if (m_cycles == CYCLE_LIMIT) m_finished = 1'b1;
        end
        if (!m_started && run_en) m_started = 1'b1;
    endtask

    // Inputs change on the falling edge; outputs are sampled on the following falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        clr           = 1'b0;
        run_en        = 1'b0;
        bus.ret_valid = 1'b0;
        bus.ret_pc    = '0;
        bus.ret_opcode = '0;
        bus.ret_funct = '0;
        bus.ret_wd    = '0;
        bus.tr_ready  = 1'b0;
    endtask

    task automatic drive_instr(int k);
        bus.ret_opcode = op_tab[k];
        bus.ret_funct  = (op_tab[k] == 6'd0) ? fn_tab[k] : 6'($urandom);
        bus.ret_pc     = $urandom;
        bus.ret_wd     = $urandom;
    endtask

    task automatic drive_random_instr();
        if ($urandom_range(0, 3) == 0) begin
            bus.ret_opcode = 6'($urandom);
            bus.ret_funct  = 6'($urandom);
            bus.ret_pc     = $urandom;
            bus.ret_wd     = $urandom;
        end else begin
            drive_instr($urandom_range(0, 9));
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({cycle_cnt, cls_cnt, overflow, done, bus.tr_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got cyc=%0d ovf=%b done=%b valid=%b expected all 0",
                     cycle_cnt, overflow, done, bus.tr_valid);
        end
        rst = 1'b0;
        model_reset();
        run_en = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.ret_valid = 1'b1;
            drive_random_instr();
            tick();
        end
        bus.ret_valid = 1'b0;
        n_checks++;
        if (bus.tr_valid !== 1'b1 || cycle_cnt !== CNT_W'(3)) begin
            n_fail++;
            $display("FAIL reset_prefill: got valid=%b cyc=%0d expected valid=1 cyc=3", bus.tr_valid, cycle_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({cycle_cnt, cls_cnt, overflow, done, bus.tr_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got cyc=%0d ovf=%b done=%b valid=%b expected all 0",
                     cycle_cnt, overflow, done, bus.tr_valid);
        end
        model_reset();
        set_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_classification();
        logic [N_CLS*CNT_W-1:0] ones;
        do_clr();
        run_en       = 1'b1;
        bus.tr_ready = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            bus.ret_valid = 1'b1;
            drive_instr(i);
            tick();
            n_checks++;
            if (bus.tr_valid !== 1'b1 || bus.tr_data[REC_W-1 -: 4] !== 4'(i) ||
                m_q.size() == 0 || bus.tr_data !== m_q[0]) begin
                n_fail++;
                $display("FAIL class_record_%0d: got valid=%b data=%h expected class %0d data=%h",
                         i, bus.tr_valid, bus.tr_data, i, (m_q.size() > 0) ? m_q[0] : '0);
            end
        end
        bus.ret_valid = 1'b0;
        tick();
        ones = '0;
        for (int k = 0; k < N_CLS; k++) ones[k*CNT_W +: CNT_W] = CNT_W'(1);
        n_checks++;
        if (cls_cnt !== ones) begin
            n_fail++;
            $display("FAIL class_counts: got %h expected %h", cls_cnt, ones);
        end
        n_checks++;
        if (cycle_cnt !== CNT_W'(10) || bus.tr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL class_cycles: got cyc=%0d valid=%b expected cyc=10 valid=0", cycle_cnt, bus.tr_valid);
        end
        set_idle();
    endtask

    task automatic test_limit();
        int n_active;
        int sum;
        do_clr();
        run_en = 1'b1;
        tick();
        n_active = 0;
        for (int t = 0; t < 40 && done !== 1'b1; t++) begin
            bus.ret_valid = 1'b1;
            bus.tr_ready  = 1'($urandom);
            drive_random_instr();
            tick();
            n_active++;
            n_checks++;
            if (done !== m_finished || bus.tr_valid !== (m_q.size() > 0) ||
                (m_q.size() > 0 && bus.tr_data !== m_q[0])) begin
                n_fail++;
                $display("FAIL limit_step_%0d: got done=%b valid=%b data=%h expected done=%b valid=%b",
                         t, done, bus.tr_valid, bus.tr_data, m_finished, m_q.size() > 0);
            end
        end
        n_checks++;
        if (done !== 1'b1 || n_active != CYCLE_LIMIT) begin
            n_fail++;
            $display("FAIL limit_done_cycle: got done=%b after %0d cycles expected done=1 after %0d",
                     done, n_active, CYCLE_LIMIT);
        end
        sum = 0;
        for (int k = 0; k < N_CLS; k++) sum += int'(cls_cnt[k*CNT_W +: CNT_W]);
        n_checks++;
        if (cycle_cnt !== CNT_W'(CYCLE_LIMIT) || sum != CYCLE_LIMIT || cls_cnt !== model_cls_vec()) begin
            n_fail++;
            $display("FAIL limit_counts: got cyc=%0d sum=%0d cls=%h expected cyc=%0d sum=%0d cls=%h",
                     cycle_cnt, sum, cls_cnt, CYCLE_LIMIT, CYCLE_LIMIT, model_cls_vec());
        end
        for (int t = 0; t < 3; t++) begin
            bus.ret_valid = 1'b1;
            drive_random_instr();
            tick();
        end
        n_checks++;
        if (cycle_cnt !== CNT_W'(CYCLE_LIMIT) || cls_cnt !== model_cls_vec() || done !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_frozen: got cyc=%0d cls=%h done=%b expected cyc=%0d cls=%h done=1",
                     cycle_cnt, cls_cnt, done, CYCLE_LIMIT, model_cls_vec());
        end
        set_idle();
    endtask

    task automatic test_pause();
        int n_ticks;
        do_clr();
        run_en       = 1'b1;
        bus.tr_ready = 1'b1;
        tick();
        n_ticks = 0;
        for (int t = 0; t < 60 && done !== 1'b1; t++) begin
            run_en        = !(t >= 5 && t < 9);
            bus.ret_valid = 1'b1;
            drive_random_instr();
            tick();
            n_ticks++;
            n_checks++;
            if (cycle_cnt !== CNT_W'(m_cycles) || cls_cnt !== model_cls_vec() ||
                (t >= 5 && t < 9 && cycle_cnt !== CNT_W'(5))) begin
                n_fail++;
                $display("FAIL pause_step_%0d: got cyc=%0d cls=%h expected cyc=%0d cls=%h",
                         t, cycle_cnt, cls_cnt, m_cycles, model_cls_vec());
            end
        end
        n_checks++;
        if (done !== 1'b1 || n_ticks != CYCLE_LIMIT + 4) begin
            n_fail++;
            $display("FAIL pause_done_cycle: got done=%b after %0d cycles expected done=1 after %0d",
                     done, n_ticks, CYCLE_LIMIT + 4);
        end
        set_idle();
    endtask

    task automatic test_fifo_full();
        int n_drained;
        do_clr();
        run_en = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.ret_valid = 1'b1;
            drive_random_instr();
            tick();
        end
        n_checks++;
        if (overflow !== 1'b1 || bus.tr_valid !== 1'b1 || m_q.size() != DEPTH) begin
            n_fail++;
            $display("FAIL fifo_overflow: got ovf=%b valid=%b expected ovf=1 valid=1 (model holds %0d)",
                     overflow, bus.tr_valid, m_q.size());
        end
        bus.tr_ready  = 1'b1;
        bus.ret_valid = 1'b1;
        drive_random_instr();
        tick();
        bus.ret_valid = 1'b0;
        run_en        = 1'b0;
        n_drained     = 0;
        for (int t = 0; t < 20 && bus.tr_valid === 1'b1; t++) begin
            n_checks++;
            if (m_q.size() == 0 || bus.tr_data !== m_q[0]) begin
                n_fail++;
                $display("FAIL fifo_drain_%0d: got %h expected %h", t, bus.tr_data,
                         (m_q.size() > 0) ? m_q[0] : '0);
            end
            n_drained++;
            tick();
        end
        n_checks++;
        if (n_drained != DEPTH || bus.tr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_drain_count: got %0d records valid=%b expected %0d records valid=0",
                     n_drained, bus.tr_valid, DEPTH);
        end
        set_idle();
    endtask

    task automatic test_clr_done();
        do_clr();
        run_en = 1'b1;
        tick();
        for (int t = 0; t < 40 && done !== 1'b1; t++) begin
            bus.ret_valid = 1'b1;
            drive_random_instr();
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || bus.tr_valid !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_setup: got done=%b valid=%b ovf=%b expected 1 1 1", done, bus.tr_valid, overflow);
        end
        clr          = 1'b1;
        bus.tr_ready = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if ({cycle_cnt, cls_cnt, overflow, done, bus.tr_valid} !== '0) begin
            n_fail++;
            $display("FAIL clr_outputs: got cyc=%0d ovf=%b done=%b valid=%b expected all 0",
                     cycle_cnt, overflow, done, bus.tr_valid);
        end
        // First cycle after clr is IDLE, so this retire must be ignored; the next one counts
        drive_random_instr();
        tick();
        n_checks++;
        if (cycle_cnt !== '0 || cls_cnt !== '0) begin
            n_fail++;
            $display("FAIL clr_idle: got cyc=%0d cls=%h expected 0", cycle_cnt, cls_cnt);
        end
        drive_random_instr();
        tick();
        n_checks++;
        if (cycle_cnt !== CNT_W'(1) || cls_cnt !== model_cls_vec()) begin
            n_fail++;
            $display("FAIL clr_restart: got cyc=%0d cls=%h expected cyc=1 cls=%h", cycle_cnt, cls_cnt, model_cls_vec());
        end
        set_idle();
    endtask

    task automatic test_random();
        do_clr();
        for (int t = 0; t < 400; t++) begin
            clr           = ($urandom_range(0, 24) == 0);
            run_en        = ($urandom_range(0, 3) != 0);
            bus.ret_valid = 1'($urandom);
            bus.tr_ready  = ($urandom_range(0, 2) == 0);
            drive_random_instr();
            tick();
            n_checks++;
            if (cycle_cnt !== CNT_W'(m_cycles) || cls_cnt !== model_cls_vec() ||
                overflow !== m_ovf || done !== m_finished || bus.tr_valid !== (m_q.size() > 0) ||
                (m_q.size() > 0 && bus.tr_data !== m_q[0])) begin
                n_fail++;
                $display("FAIL random_%0d: got cyc=%0d ovf=%b done=%b valid=%b data=%h expected cyc=%0d ovf=%b done=%b valid=%b data=%h",
                         t, cycle_cnt, overflow, done, bus.tr_valid, bus.tr_data,
                         m_cycles, m_ovf, m_finished, m_q.size() > 0, (m_q.size() > 0) ? m_q[0] : '0);
            end
        end
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        model_reset();
        test_reset();
        test_classification();
        test_limit();
        test_pause();
        test_fifo_full();
        test_clr_done();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end
endmodule
